page_mapper: RTL and testbench
==============================

// Module: page_mapper
// PURPOSE
//   Bus-side consumer of the page/RAM-disable/lock control register outputs. It sits
//   between the CPU bus and the external ROM/RAM devices. It does three things:
//   - translates each 16-bit CPU address into an 18-bit external address plus a
//     ROM/RAM select;
//   - generates per-device wait states by holding the CPU;
//   - blocks writes to locked ROM pages and latches a fault for software.
// PARAMETERS
//   WAIT_ROM  2  extra hold cycles for an external ROM access (0..15)
//   WAIT_RAM  1  extra hold cycles for an external RAM access (0..15)
// PORTS
//   clk         in   1   system clock; all state changes on rising edge
//   rst         in   1   asynchronous, active-high reset
//   cpu_addr    in   16  CPU address; CPU keeps it stable while cpu_hold=1
//   cpu_rw      in   1   1=read, 0=write
//   cpu_vma     in   1   valid memory access this cycle
//   page        in   5   {R,PPP..}: page[4]=1 maps ROM into window, page[3:0]=bank
//   bram_disable in  1   1 = built-in RAM at $0000-$0FFF disabled
//   rom_lock    in   1   1 = writes to ROM are forbidden
//   fault_clr   in   1   one-cycle pulse, clears wp_fault
//   bram_cs     out  1   built-in RAM select (combinational)
//   mem_ce      out  1   external device strobe
//   mem_we      out  1   external write strobe (only with mem_ce)
//   rom_sel     out  1   1=ROM device, 0=RAM device
//   ext_addr    out  18  external address
//   cpu_hold    out  1   stall CPU; combinational
//   wp_fault    out  1   sticky write-protect violation flag
//   fault_addr  out  16  CPU address of the first violation since last clear
// BEHAVIOUR
//   Decode (applied to the live bus in IDLE, to latched values in ACCESS):
//   - BRAM:   cpu_addr<$1000 && !bram_disable -> bram_cs=vma. No external cycle, no hold.
//   - WINDOW: cpu_addr[15:14]=2'b10 -> ext_addr={page[3:0],cpu_addr[13:0]}, rom_sel=page[4].
//   - Any other address -> RAM, ext_addr={2'b00,cpu_addr}, rom_sel=0.
//   Wait count for an access: W = rom_sel ? WAIT_ROM : WAIT_RAM.
//   FSM with states IDLE and ACCESS; 4-bit down counter cnt.
//   IDLE, vma && external target:
//   - mem_ce=1, and mem_we=!cpu_rw unless blocked;
//     outputs driven from the live bus and page.
//   - Latch addr, rw, page, rom_sel.
//   - If W>0: cpu_hold=1, cnt<=W-1, go to ACCESS.
//   - If W=0: single-cycle access, stay in IDLE, no hold.
//   ACCESS:
//   - Outputs driven from the latched copy; a page change mid-access has no effect.
//   - mem_ce=1.
//   - cnt!=0: cpu_hold=1, cnt decrements.
//   - cnt=0: cpu_hold=0; this is the final cycle of the access. Next state is IDLE.
//   - The CPU samples read data on the cycle where hold=0.
//   Total access length is W+1 cycles; cpu_hold is high for exactly W cycles.
//   Write protect: a write with rom_sel=1 && rom_lock=1 is blocked.
//   - mem_we=0 for the whole access, mem_ce stays 0, cpu_hold=0, zero wait, no ACCESS state.
//   - wp_fault<=1 on the next edge.
//   - fault_addr is loaded only if wp_fault was 0 (first fault kept).
//   - fault_clr and a new violation in the same cycle: the set wins and
//     fault_addr is loaded with the new address.
//   cpu_vma=0 in IDLE: all strobes are 0 and ext_addr still follows the decode.
//   Reset, asynchronous, including mid-ACCESS:
//   - state=IDLE, cnt=0, cpu_hold=0, mem_ce=0, mem_we=0;
//     wp_fault=0, fault_addr=$0000, latched page=0.
//   - The aborted access is not resumed.
// TESTING
//   - After reset (bram_disable=1, page=0):
//     all strobes 0, cpu_hold=0, wp_fault=0, fault_addr=$0000.
//   - page=5'h03, read $8123, WAIT_RAM=1:
//     ext_addr=18'h0C123, rom_sel=0, cpu_hold high 1 cycle, mem_ce high 2 cycles.
//   - page=5'h12, read $BFFF, WAIT_ROM=2:
//     ext_addr=18'h0BFFF, rom_sel=1, hold 2 cycles.
//     Changing page during the hold leaves ext_addr unchanged.
//   - page=5'h10, rom_lock=1, write $8000:
//     mem_we=0, mem_ce=0, no hold, wp_fault=1, fault_addr=$8000.
//     A second violation at $8001 keeps $8000.
//     fault_clr in the same cycle as the $8001 violation -> wp_fault=1, fault_addr=$8001.
//   - bram_disable=0, read $0042: bram_cs=1, mem_ce=0, no hold.
//     bram_disable=1, read $0042: external RAM, ext_addr=18'h00042.
//   - rst asserted during ACCESS on a ROM read:
//     cpu_hold/mem_ce drop immediately.
//     After release, a RAM read at $4000 completes normally with ext_addr=18'h04000.

Source files
------------

// File: rtl/page_mapper_if.sv
// Bus interface of the page mapper.
// The CPU side drives cpu_addr, cpu_rw and cpu_vma, and receives cpu_hold.
// The memory side receives bram_cs, mem_ce, mem_we, rom_sel and ext_addr.
// The master modport is the CPU/bench view of the bus.
// The slave modport is the mapper's view of the bus.
interface page_mapper_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_vma;
    logic        cpu_hold;
    logic        bram_cs;
    logic        mem_ce;
    logic        mem_we;
    logic        rom_sel;
    logic [17:0] ext_addr;

    modport master (
        output cpu_addr, cpu_rw, cpu_vma,
        input  cpu_hold, bram_cs, mem_ce, mem_we, rom_sel, ext_addr
    );

    modport slave (
        input  cpu_addr, cpu_rw, cpu_vma,
        output cpu_hold, bram_cs, mem_ce, mem_we, rom_sel, ext_addr
    );
endinterface

// File: rtl/page_mapper.sv
// Page mapper. Translates CPU addresses to external ROM/RAM addresses and
// inserts per-device wait states. It also blocks writes to locked ROM and
// records the first write-protect violation.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   bus            CPU and memory bus signals (page_mapper_if.slave)
//   page           {rom, bank[3:0]} selection for the $8000-$BFFF window
//   bram_disable   disables the built-in RAM at $0000-$0FFF
//   rom_lock       forbids writes to ROM
//   fault_clr      pulse that clears wp_fault
//   wp_fault       sticky write-protect violation flag
//   fault_addr     CPU address of the first violation since the last clear
module page_mapper #(
    parameter int unsigned WAIT_ROM = 2,
    parameter int unsigned WAIT_RAM = 1
) (
    input  logic              clk,
    input  logic              rst,
    page_mapper_if.slave      bus,
    input  logic [4:0]        page,
    input  logic              bram_disable,
    input  logic              rom_lock,
    input  logic              fault_clr,
    output logic              wp_fault,
    output logic [15:0]       fault_addr
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        lat_addr;
    logic               lat_rw;
    logic [4:0]         lat_page;
    logic               lat_rom_sel;

    logic               in_access;
    logic [15:0]        sel_addr;
    logic [4:0]         sel_page;
    logic               is_bram;
    logic [17:0]        dec_addr;
    logic               dec_rom;
    logic [CNT_W-1:0]   wait_cnt;
    logic               ext_go;
    logic               blocked;
    logic               start;

    // Decode: the live bus while idle, the latched copy during a held access
    always_comb begin
        in_access = (state == S_ACCESS);
        sel_addr  = in_access ? lat_addr : bus.cpu_addr;
        sel_page  = in_access ? lat_page : page;
        is_bram   = (bus.cpu_addr[15:12] == 4'h0) && !bram_disable;

        if (sel_addr[15:14] == 2'b10) begin
            dec_addr = {sel_page[3:0], sel_addr[13:0]};
            dec_rom  = sel_page[4];
        end else begin
            dec_addr = {2'b00, sel_addr};
            dec_rom  = 1'b0;
        end

        wait_cnt = dec_rom ? CNT_W'(WAIT_ROM) : CNT_W'(WAIT_RAM);
        ext_go   = !in_access && bus.cpu_vma && !is_bram;
        blocked  = ext_go && !bus.cpu_rw && dec_rom && rom_lock;
        start    = ext_go && !blocked;
    end

    // Bus outputs; a blocked write produces no strobe and no stall
    always_comb begin
        bus.bram_cs  = !in_access && bus.cpu_vma && is_bram;
        bus.ext_addr = dec_addr;
        bus.rom_sel  = in_access ? lat_rom_sel : dec_rom;
        bus.mem_ce   = in_access || start;
        bus.mem_we   = in_access ? !lat_rw : (start && !bus.cpu_rw);
        bus.cpu_hold = in_access ? (cnt != '0) : (start && (wait_cnt != '0));
    end

    // Access sequencer, latched access copy and write-protect fault capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_rw      <= 1'b1;
            lat_page    <= '0;
            lat_rom_sel <= 1'b0;
            wp_fault    <= 1'b0;
            fault_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_addr    <= bus.cpu_addr;
                        lat_rw      <= bus.cpu_rw;
                        lat_page    <= page;
                        lat_rom_sel <= dec_rom;
                        if (wait_cnt != '0) begin
                            cnt   <= wait_cnt - CNT_W'(1);
                            state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new violation beats a simultaneous clear; the first address is kept otherwise
            if (blocked) begin
                wp_fault <= 1'b1;
                if (!wp_fault || fault_clr) begin
                    fault_addr <= bus.cpu_addr;
                end
            end else if (fault_clr) begin
                wp_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_page_mapper.sv
// Directed bench for page_mapper with WAIT_ROM=2 and WAIT_RAM=1.
// Inputs change 1 time unit after a rising edge.
// Outputs are checked at the following falling edge.
module tb_page_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  page;
    logic        bram_disable;
    logic        rom_lock;
    logic        fault_clr;
    logic        wp_fault;
    logic [15:0] fault_addr;

    int compared   = 0;
    int mismatched = 0;

    page_mapper_if bus ();

    page_mapper #(.WAIT_ROM(2), .WAIT_RAM(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .page         (page),
        .bram_disable (bram_disable),
        .rom_lock     (rom_lock),
        .fault_clr    (fault_clr),
        .wp_fault     (wp_fault),
        .fault_addr   (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_rw   = 1'b1;
        bus.cpu_vma  = 1'b0;
        page         = 5'h00;
        bram_disable = 1'b1;
        rom_lock     = 1'b0;
        fault_clr    = 1'b0;

        // Reset state
        #12;
        chk("rst_ce",    32'(bus.mem_ce),   32'h0);
        chk("rst_we",    32'(bus.mem_we),   32'h0);
        chk("rst_bcs",   32'(bus.bram_cs),  32'h0);
        chk("rst_hold",  32'(bus.cpu_hold), 32'h0);
        chk("rst_fault", 32'(wp_fault),     32'h0);
        chk("rst_faddr", 32'(fault_addr),   32'h0);
        nxt();
        rst = 1'b0;
        #4;
        chk("idle_ce",   32'(bus.mem_ce),   32'h0);

        // RAM window read, one wait state
        nxt();
        bus.cpu_addr = 16'h8123; bus.cpu_rw = 1'b1; bus.cpu_vma = 1'b1; page = 5'h03;
        #4;
        chk("ram_ext0",  32'(bus.ext_addr), 32'h0C123);
        chk("ram_rom0",  32'(bus.rom_sel),  32'h0);
        chk("ram_ce0",   32'(bus.mem_ce),   32'h1);
        chk("ram_we0",   32'(bus.mem_we),   32'h0);
        chk("ram_hold0", 32'(bus.cpu_hold), 32'h1);
        nxt();
        #4;
        chk("ram_ce1",   32'(bus.mem_ce),   32'h1);
        chk("ram_hold1", 32'(bus.cpu_hold), 32'h0);
        chk("ram_ext1",  32'(bus.ext_addr), 32'h0C123);
        nxt();
        bus.cpu_vma = 1'b0;
        #4;
        chk("ram_ce2",   32'(bus.mem_ce),   32'h0);
        chk("ram_hold2", 32'(bus.cpu_hold), 32'h0);

        // ROM window read, two wait states, page changed mid-access
        nxt();
        bus.cpu_addr = 16'hBFFF; bus.cpu_vma = 1'b1; page = 5'h12;
        #4;
        chk("rom_ext0",  32'(bus.ext_addr), 32'h0BFFF);
        chk("rom_sel0",  32'(bus.rom_sel),  32'h1);
        chk("rom_ce0",   32'(bus.mem_ce),   32'h1);
        chk("rom_hold0", 32'(bus.cpu_hold), 32'h1);
        nxt();
        page = 5'h05;
        #4;
        chk("rom_ext1",  32'(bus.ext_addr), 32'h0BFFF);
        chk("rom_sel1",  32'(bus.rom_sel),  32'h1);
        chk("rom_hold1", 32'(bus.cpu_hold), 32'h1);
        nxt();
        #4;
        chk("rom_hold2", 32'(bus.cpu_hold), 32'h0);
        chk("rom_ce2",   32'(bus.mem_ce),   32'h1);
        chk("rom_ext2",  32'(bus.ext_addr), 32'h0BFFF);
        nxt();
        bus.cpu_vma = 1'b0; page = 5'h10;
        #4;
        chk("rom_ce3",   32'(bus.mem_ce),   32'h0);

        // Write-protect violations
        nxt();
        bus.cpu_addr = 16'h8000; bus.cpu_rw = 1'b0; bus.cpu_vma = 1'b1; rom_lock = 1'b1;
        #4;
        chk("wp_we0",    32'(bus.mem_we),   32'h0);
        chk("wp_ce0",    32'(bus.mem_ce),   32'h0);
        chk("wp_hold0",  32'(bus.cpu_hold), 32'h0);
        chk("wp_rom0",   32'(bus.rom_sel),  32'h1);
        chk("wp_flag0",  32'(wp_fault),     32'h0);
        nxt();
        bus.cpu_addr = 16'h8001;
        #4;
        chk("wp_flag1",  32'(wp_fault),     32'h1);
        chk("wp_faddr1", 32'(fault_addr),   32'h8000);
        chk("wp_ce1",    32'(bus.mem_ce),   32'h0);
        nxt();
        fault_clr = 1'b1;
        #4;
        chk("wp_faddr2", 32'(fault_addr),   32'h8000);
        nxt();
        fault_clr = 1'b0; bus.cpu_vma = 1'b0;
        #4;
        chk("wp_flag3",  32'(wp_fault),     32'h1);
        chk("wp_faddr3", 32'(fault_addr),   32'h8001);

        // A RAM write is not affected by rom_lock
        nxt();
        bus.cpu_addr = 16'h4000; bus.cpu_rw = 1'b0; bus.cpu_vma = 1'b1;
        #4;
        chk("rw_we0",    32'(bus.mem_we),   32'h1);
        chk("rw_ce0",    32'(bus.mem_ce),   32'h1);
        chk("rw_hold0",  32'(bus.cpu_hold), 32'h1);
        chk("rw_ext0",   32'(bus.ext_addr), 32'h04000);
        nxt();
        #4;
        chk("rw_we1",    32'(bus.mem_we),   32'h1);
        chk("rw_hold1",  32'(bus.cpu_hold), 32'h0);
        nxt();
        bus.cpu_vma = 1'b0; bus.cpu_rw = 1'b1;
        #4;
        chk("rw_we2",    32'(bus.mem_we),   32'h0);

        // Built-in RAM enabled, then disabled
        nxt();
        bram_disable = 1'b0; bus.cpu_addr = 16'h0042; bus.cpu_vma = 1'b1;
        #4;
        chk("br_cs0",    32'(bus.bram_cs),  32'h1);
        chk("br_ce0",    32'(bus.mem_ce),   32'h0);
        chk("br_hold0",  32'(bus.cpu_hold), 32'h0);
        nxt();
        bram_disable = 1'b1;
        #4;
        chk("br_cs1",    32'(bus.bram_cs),  32'h0);
        chk("br_ce1",    32'(bus.mem_ce),   32'h1);
        chk("br_ext1",   32'(bus.ext_addr), 32'h00042);
        chk("br_rom1",   32'(bus.rom_sel),  32'h0);
        chk("br_hold1",  32'(bus.cpu_hold), 32'h1);
        nxt();
        #4;
        chk("br_hold2",  32'(bus.cpu_hold), 32'h0);
        nxt();
        bus.cpu_vma = 1'b0;

        // Reset in the middle of a ROM access
        nxt();
        bus.cpu_addr = 16'hBFFF; bus.cpu_vma = 1'b1; page = 5'h12;
        #4;
        chk("ra_hold0",  32'(bus.cpu_hold), 32'h1);
        nxt();
        #4;
        chk("ra_hold1",  32'(bus.cpu_hold), 32'h1);
        chk("ra_ce1",    32'(bus.mem_ce),   32'h1);
        #1;
        rst = 1'b1; bus.cpu_vma = 1'b0;
        #1;
        chk("ra_hold2",  32'(bus.cpu_hold), 32'h0);
        chk("ra_ce2",    32'(bus.mem_ce),   32'h0);
        chk("ra_flag2",  32'(wp_fault),     32'h0);
        chk("ra_faddr2", 32'(fault_addr),   32'h0);
        nxt();
        nxt();
        rst = 1'b0;
        #4;
        chk("ra_ce3",    32'(bus.mem_ce),   32'h0);
        chk("ra_hold3",  32'(bus.cpu_hold), 32'h0);
        nxt();
        bus.cpu_addr = 16'h4000; bus.cpu_rw = 1'b1; bus.cpu_vma = 1'b1;
        #4;
        chk("ra_ext4",   32'(bus.ext_addr), 32'h04000);
        chk("ra_rom4",   32'(bus.rom_sel),  32'h0);
        chk("ra_ce4",    32'(bus.mem_ce),   32'h1);
        chk("ra_hold4",  32'(bus.cpu_hold), 32'h1);
        nxt();
        #4;
        chk("ra_hold5",  32'(bus.cpu_hold), 32'h0);
        chk("ra_ce5",    32'(bus.mem_ce),   32'h1);
        nxt();
        bus.cpu_vma = 1'b0;
        #4;
        chk("ra_ce6",    32'(bus.mem_ce),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
